// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: iterative AES encryption controller. A single external
// one_round/final_round datapath is reused for all NR rounds of a block. The
// datapath inputs are held stable for ROUND_LAT+1 cycles, and the result is
// captured on the last cycle of each round.
module aes_round_sequencer #(
  parameter int NR        = 10,
  parameter int ROUND_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic [127:0] rnd_state,
  output logic [127:0] rnd_key,
  input  logic [127:0] rnd_result,
  input  logic [127:0] fin_result,
  output logic         busy
);

  localparam int              WCNT_W    = $clog2(ROUND_LAT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(ROUND_LAT);
  localparam logic [3:0]      RND_FINAL = 4'(NR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_e;

  state_e              fsm_q, fsm_d;
  logic [127:0]        state_reg_q, state_reg_d;
  logic [3:0]          rnd_q, rnd_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [127:0]        out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                round_done;

  // The datapath result is ready on the last cycle of the hold window.
  assign round_done = (wcnt_q == WCNT_LAST);

  assign in_ready  = (fsm_q == S_IDLE);
  assign busy      = (fsm_q == S_ROUND) || (fsm_q == S_FINAL);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign rnd_state = state_reg_q;
  assign rnd_key   = rk_data;

  // Next-state, round sequencing and round-key index selection.
  always_comb begin
    // NOTE: every next-state value defaults to its hold value first, so no
    // path through the case statement can infer a latch.
    fsm_d       = fsm_q;
    state_reg_d = state_reg_q;
    rnd_d       = rnd_q;
    wcnt_d      = wcnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    rk_idx      = 4'd0;

    case (fsm_q)
      S_IDLE: begin
        // Key 0 is on rk_data now, so initial whitening happens at accept.
        if (in_valid && in_ready) begin
          state_reg_d = in_data ^ rk_data;
          rnd_d       = 4'd1;
          wcnt_d      = '0;
          fsm_d       = (NR == 1) ? S_FINAL : S_ROUND;
        end
      end

      S_ROUND: begin
        rk_idx = rnd_q;
        if (round_done) begin
          state_reg_d = rnd_result;
          rnd_d       = rnd_q + 4'd1;
          wcnt_d      = '0;
          if (rnd_q + 4'd1 == RND_FINAL) begin
            fsm_d = S_FINAL;
          end
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end

      S_FINAL: begin
        rk_idx = RND_FINAL;
        if (round_done) begin
          out_data_d  = fin_result;
          out_valid_d = 1'b1;
          wcnt_d      = '0;
          fsm_d       = S_DONE;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end

      S_DONE: begin
        // Hold the ciphertext until the consumer takes it.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = S_IDLE;
        end
      end

      default: fsm_d = S_IDLE;
    endcase
  end

  // State and datapath registers; a reset abandons any block in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the 128-bit state and output registers are reset as well, so
      // rnd_state and out_data read zero straight out of reset.
      fsm_q       <= S_IDLE;
      state_reg_q <= '0;
      rnd_q       <= 4'd0;
      wcnt_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only, so every register updates from
      // pre-edge values regardless of statement order.
      fsm_q       <= fsm_d;
      state_reg_q <= state_reg_d;
      rnd_q       <= rnd_d;
      wcnt_q      <= wcnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
